axi_read_responder: RTL
=======================

Name: axi_read_responder

Overview:
- AXI3-style read-only slave that answers the burst read requests Flipper issues on its 128-bit memory master port.
- Serves data from a synchronous single-port memory with 1-cycle read latency (BRAM or simulation RAM model).
- Used as main-memory stand-in for Flipper bring-up and as the slave side of the same read channel inside the emulator fabric.
- Accepts one burst at a time and streams len+1 beats with correct RLAST, RRESP and backpressure handling.

Parameters:
- MEM_AW, 12, memory word-address width; memory holds 2^MEM_AW 128-bit words.
- BASE_ADDR, 32'h0000_0000, byte address mapped to memory word 0; must be 16-byte aligned.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- araddr  in  32  burst start byte address
- arburst  in  2  0 FIXED, 1 INCR, 2 WRAP, 3 reserved
- arlen  in  4  beats minus one
- arsize  in  3  bytes per beat = 1<<arsize
- arvalid  in  1  address valid
- arready  out  1  address accept
- rdata  out  128  read data
- rresp  out  2  0 OKAY, 2 SLVERR, 3 DECERR
- rlast  out  1  final beat of burst
- rvalid  out  1  data valid
- rready  in  1  data accept
- mem_en  out  1  memory read strobe
- mem_addr  out  MEM_AW  memory word address
- mem_rdata  in  128  memory data, valid the cycle after mem_en

Behaviour:
- Reset values: arready=0, rvalid=0, rlast=0, rresp=0, rdata=0, mem_en=0, mem_addr=0. Asserting reset mid-burst drops the burst immediately; no beats follow deassertion.
- States: IDLE and BURST. IDLE drives arready=1 from the first cycle after reset release. AR handshake (arvalid&&arready) latches araddr, arburst, arlen, arsize and moves to BURST. In BURST arready=0.
- Request legality, decided at AR time:
  - arsize>4 or arburst==3 gives SLVERR on all beats.
  - WRAP with arlen not in {1,3,7,15} gives SLVERR on all beats.
  - SLVERR beats carry rdata=0 and never assert mem_en.
  - The burst always returns exactly arlen+1 beats.
- Beat address sequence:
  - FIXED: every beat reads araddr.
  - INCR: addr += 1<<arsize per beat, 32-bit wrap-around.
  - WRAP: container size = (arlen+1)<<arsize; the address wraps to the container-aligned base on crossing the boundary.
  - mem_addr = (addr-BASE_ADDR)[MEM_AW+3:4]; unaligned low bits are ignored, and the full 128-bit word is returned.
- Decode error: if addr<BASE_ADDR or addr-BASE_ADDR >= 16<<MEM_AW, that beat is DECERR with rdata=0 and no mem_en. Other beats are unaffected.
- Pipeline and backpressure:
  - Memory read issue happens in cycle N; data is captured into a 2-entry skid FIFO in cycle N+1.
  - R outputs are driven from the FIFO head. rlast and rresp travel in the FIFO alongside the data.
  - Issue a read (or an error beat) only when occupancy + in-flight < 2, so no data is ever lost while rready=0.
  - With rready held high, throughput is 1 beat/cycle. Latency from AR handshake to first rvalid is 2 cycles.
  - rdata, rresp and rlast stay stable while rvalid && !rready.
- Completion: on the handshake of the beat with rlast=1, return to IDLE. arready rises the next cycle, so at most one burst is outstanding.
- Simultaneous events: an AR presented during BURST waits (arready=0). FIFO push and pop in the same cycle keep occupancy unchanged.

Decomposition:
- Shared package flipper_axi_pkg holds: burst encodings (FIXED/INCR/WRAP), RRESP codes (OKAY/SLVERR/DECERR), the 128-bit beat width constant, and the beat-size field width.
- One natural sub-module, axi_skid_fifo: 2-entry, 131-bit wide (data+resp+last), valid/ready on both sides. The address generator and FSM stay in the top module.

Test Plan:
1. Memory word k = {4{k}}; AR araddr=0, arburst=1, arlen=4, arsize=3, rready=1 -> 5 beats with words 0,0,1,1,2, rresp=0, rlast only on beat 5, first rvalid 2 cycles after the AR handshake.
2. INCR araddr=0x20, arlen=3, arsize=4; rready toggles 1,0,0,1,... -> words 2,3,4,5 in order, each held stable while stalled, no beat dropped or duplicated.
3. WRAP araddr=0x30, arlen=3, arsize=4 -> words 3,0,1,2; WRAP with arlen=2 -> 3 beats of SLVERR, rdata=0, mem_en never asserted.
4. MEM_AW=4, INCR araddr=0xE0, arlen=3, arsize=4 -> words 14,15 OKAY, then 2 beats DECERR with rdata=0; rlast on beat 4.
5. arsize=5 or arburst=3, arlen=0 -> single beat SLVERR with rlast=1; second AR accepted the cycle after that beat's handshake.
6. Assert reset during beat 2 of an arlen=7 burst -> rvalid and arready fall immediately; after release, arready=1 and a new arlen=0 burst returns exactly one correct beat.

Source files
------------

// File: rtl/flipper_axi_pkg.sv
// flipper_axi_pkg
// Shared definitions for the Flipper 128-bit AXI3-style read channel:
// burst type encodings, RRESP codes, beat/field widths, the read
// responder FSM states and a helper for WRAP length legality.
package flipper_axi_pkg;

  localparam int BEAT_W = 128;
  localparam int SIZE_W = 3;
  localparam int RESP_W = 2;
  localparam int RFIFO_W = BEAT_W + RESP_W + 1;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2,
    BURST_RSVD  = 2'd3
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'd0,
    RESP_EXOKAY = 2'd1,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } resp_e;

  typedef enum logic {
    RD_IDLE  = 1'b0,
    RD_BURST = 1'b1
  } rd_state_e;

  // WRAP bursts are only meaningful for 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [3:0] len);
    return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
  endfunction

endpackage

// File: rtl/axi_skid_fifo.sv
// axi_skid_fifo
// Two-entry FIFO with valid/ready on both sides. Used to hold read beats
// (data + resp + last) so the R channel can stall without losing data
// already fetched from memory.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   in_valid/in_ready     write side handshake
//   in_data [W]           entry written on push
//   out_valid/out_ready   read side handshake
//   out_data [W]          head entry, stable until popped
//   count [2]             current occupancy (0..2)
module axi_skid_fifo #(
  parameter int W = 131
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   count
);

  logic [W-1:0] entry [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         push;
  logic         pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = entry[rd_ptr];

  // Entries are cleared on reset so the head reads as zero until the
  // first push.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entry[0] <= '0;
      entry[1] <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
    end else begin
      if (push) begin
        entry[wr_ptr] <= in_data;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/axi_read_responder.sv
// axi_read_responder
// Read-only AXI3-style slave serving one burst at a time from a
// synchronous single-port 128-bit memory with one cycle of read latency.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   araddr/arburst/arlen/arsize/arvalid/arready   AR channel
//   rdata/rresp/rlast/rvalid/rready               R channel
//   mem_en/mem_addr     memory read strobe and word address
//   mem_rdata           memory data, valid the cycle after mem_en
module axi_read_responder
  import flipper_axi_pkg::*;
#(
  parameter int          MEM_AW    = 12,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       araddr,
  input  logic [1:0]        arburst,
  input  logic [3:0]        arlen,
  input  logic [SIZE_W-1:0] arsize,
  input  logic              arvalid,
  output logic              arready,
  output logic [BEAT_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  output logic              mem_en,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [BEAT_W-1:0] mem_rdata
);

  localparam logic [32:0] MEM_BYTES = 33'd16 << MEM_AW;

  rd_state_e         state;
  rd_state_e         state_next;
  logic              arready_q;
  logic              ar_hs;
  logic              issue;
  logic              space;
  logic              pop;

  logic [31:0]       addr;
  logic [31:0]       addr_next;
  logic [31:0]       offset;
  logic [31:0]       bytes;
  logic [31:0]       wrap_mask;
  logic [1:0]        burst;
  logic [3:0]        len;
  logic [SIZE_W-1:0] size;
  logic              slverr;
  logic [4:0]        remaining;
  logic              beat_decerr;
  logic [1:0]        beat_resp;

  logic              infl_valid;
  logic              infl_last;
  logic              infl_mem;
  logic [1:0]        infl_resp;

  logic              fifo_in_ready;
  logic [1:0]        fifo_count;
  logic [RFIFO_W-1:0] push_data;
  logic [RFIFO_W-1:0] head_data;

  assign arready = arready_q;
  assign pop     = rvalid && rready;

  // A new beat may be issued only if the FIFO will have room for it when
  // its data returns, counting the beat already in flight and any pop
  // happening this cycle. The pop term keeps full throughput with rready
  // held high.
  assign space = infl_valid ? ((fifo_count == 2'd0) || pop)
                            : (fifo_in_ready || pop);

  // Per-beat decode against the memory window and the burst legality
  // decided when the request was accepted.
  assign offset      = addr - BASE_ADDR;
  assign beat_decerr = (addr < BASE_ADDR) || ({1'b0, offset} >= MEM_BYTES);
  assign beat_resp   = slverr      ? RESP_SLVERR :
                       beat_decerr ? RESP_DECERR : RESP_OKAY;

  assign mem_en   = issue && (beat_resp == RESP_OKAY);
  assign mem_addr = mem_en ? MEM_AW'(offset >> 4) : '0;

  // Address of the following beat. WRAP keeps the bits above the
  // container size and lets only the low bits advance.
  always_comb begin
    bytes     = 32'd1 << size;
    wrap_mask = (({28'd0, len} + 32'd1) << size) - 32'd1;
    addr_next = addr + bytes;
    case (burst)
      BURST_FIXED: addr_next = addr;
      BURST_WRAP:  addr_next = (addr & ~wrap_mask) | ((addr + bytes) & wrap_mask);
      default:     addr_next = addr + bytes;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RD_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and issue decision. The burst ends on the handshake of
  // the beat carrying rlast.
  always_comb begin
    state_next = state;
    ar_hs      = 1'b0;
    issue      = 1'b0;
    case (state)
      RD_IDLE: begin
        ar_hs = arvalid && arready_q;
        if (ar_hs) begin
          state_next = RD_BURST;
        end
      end
      RD_BURST: begin
        issue = (remaining != 5'd0) && space;
        if (pop && rlast) begin
          state_next = RD_IDLE;
        end
      end
      default: state_next = RD_IDLE;
    endcase
  end

  // Request capture, beat sequencing and the one-cycle in-flight stage
  // that lines up beat attributes with the memory read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arready_q  <= 1'b0;
      addr       <= 32'd0;
      burst      <= 2'd0;
      len        <= 4'd0;
      size       <= '0;
      slverr     <= 1'b0;
      remaining  <= 5'd0;
      infl_valid <= 1'b0;
      infl_last  <= 1'b0;
      infl_mem   <= 1'b0;
      infl_resp  <= 2'd0;
    end else begin
      arready_q <= (state_next == RD_IDLE);
      if (ar_hs) begin
        addr      <= araddr;
        burst     <= arburst;
        len       <= arlen;
        size      <= arsize;
        slverr    <= (arsize > 3'd4) || (arburst == BURST_RSVD) ||
                     ((arburst == BURST_WRAP) && !wrap_len_ok(arlen));
        remaining <= {1'b0, arlen} + 5'd1;
      end else if (issue) begin
        addr      <= addr_next;
        remaining <= remaining - 5'd1;
      end
      infl_valid <= issue;
      infl_last  <= (remaining == 5'd1);
      infl_mem   <= mem_en;
      infl_resp  <= beat_resp;
    end
  end

  assign push_data = {infl_resp, infl_last, (infl_mem ? mem_rdata : {BEAT_W{1'b0}})};

  axi_skid_fifo #(.W(RFIFO_W)) u_rfifo (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (infl_valid),
    .in_ready  (fifo_in_ready),
    .in_data   (push_data),
    .out_valid (rvalid),
    .out_ready (rready),
    .out_data  (head_data),
    .count     (fifo_count)
  );

  assign rresp = head_data[RFIFO_W-1 -: 2];
  assign rlast = head_data[BEAT_W];
  assign rdata = head_data[BEAT_W-1:0];

endmodule
